// File: rtl/mc_control.sv
// Multi-cycle Moore control sequencer for the MIPS-lite datapath.
// Optional memory wait states: define MC_CONTROL_MEMWAIT_EN.
module mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic [4:0] branchf,
  input  logic       memready,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regdest,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluop,
  output logic [1:0] pcsource,
  output logic [2:0] branch,
  output logic       jalcntrl,
  output logic       alusrcz,
  output logic       instret,
  output logic       badop,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_REXEC  = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_IEXEC  = 4'd8;
  localparam logic [3:0] S_IWB    = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JAL    = 4'd12;
  localparam logic [3:0] S_JR     = 4'd13;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] FN_JR     = 6'b001000;

  logic [3:0] cur;
  logic [3:0] nxt;
  logic       memok;
  logic       unusedbranchf;

  // Only bit 0 of the rt field matters (bgez vs bltz).
  assign unusedbranchf = ^branchf[4:1];

`ifdef MC_CONTROL_MEMWAIT_EN
  assign memok = memready;
`else
  logic unusedmemready;
  assign unusedmemready = memready;
  assign memok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  // Moore decode of the current state; reset blanks every output at the end.
  always_comb begin
    nxt      = S_FETCH;
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    regdest  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 4'b0000;
    pcsource = 2'b00;
    branch   = 3'b000;
    jalcntrl = 1'b0;
    alusrcz  = 1'b0;
    instret  = 1'b0;
    badop    = 1'b0;
    state    = cur;

    case (cur)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = memok;
        pcwrite = memok;
        nxt     = memok ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_RTYPE:                 nxt = (func == FN_JR) ? S_JR : S_REXEC;
          OP_LW, OP_SW:             nxt = S_MEMADR;
          OP_ADDI, OP_ANDI, OP_ORI: nxt = S_IEXEC;
          OP_BEQ, OP_BNE, OP_REGIMM,
          OP_BGTZ, OP_BLEZ:         nxt = S_BRANCH;
          OP_J:                     nxt = S_JUMP;
          OP_JAL:                   nxt = S_JAL;
          default: begin
            badop = 1'b1;
            nxt   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        nxt     = memok ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        instret  = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        instret  = memok;
        nxt      = memok ? S_FETCH : S_MEMWR;
      end
      S_REXEC: begin
        alusrca = 1'b1;
        aluop   = 4'b0001;
        nxt     = S_RWB;
      end
      S_RWB: begin
        regwrite = 1'b1;
        regdest  = 1'b1;
        instret  = 1'b1;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (opcode)
          OP_ANDI: aluop = 4'b0100;
          OP_ORI:  aluop = 4'b1000;
          default: aluop = 4'b0000;
        endcase
        nxt = S_IWB;
      end
      S_IWB: begin
        regwrite = 1'b1;
        instret  = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 4'b0010;
        pcsource = 2'b01;
        instret  = 1'b1;
        case (opcode)
          OP_BEQ:  branch = 3'b001;
          OP_BNE:  branch = 3'b010;
          OP_REGIMM: begin
            branch  = branchf[0] ? 3'b011 : 3'b110;
            alusrcz = 1'b1;
          end
          OP_BGTZ: begin
            branch  = 3'b100;
            alusrcz = 1'b1;
          end
          OP_BLEZ: branch = 3'b101;
          default: branch = 3'b000;
        endcase
      end
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
        instret  = 1'b1;
      end
      S_JAL: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
        regwrite = 1'b1;
        jalcntrl = 1'b1;
        instret  = 1'b1;
      end
      S_JR: begin
        pcwrite  = 1'b1;
        pcsource = 2'b11;
        instret  = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase

    if (rst) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      iord     = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      memtoreg = 1'b0;
      regdest  = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      aluop    = 4'b0000;
      pcsource = 2'b00;
      branch   = 3'b000;
      jalcntrl = 1'b0;
      alusrcz  = 1'b0;
      instret  = 1'b0;
      badop    = 1'b0;
      state    = 4'd0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-cycle expectations are queued by the
// stimulus process and checked by a monitor on the falling clock edge.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] func = 6'd0;
  logic [4:0] branchf = 5'd0;
  logic       memready = 1'b1;
  logic       pcwrite, irwrite, iord, memread, memwrite, memtoreg;
  logic       regdest, regwrite, alusrca, jalcntrl, alusrcz, instret, badop;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluop, state;
  logic [2:0] branch;
  logic [23:0] outs;

  mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .branchf(branchf),
    .memready(memready), .pcwrite(pcwrite), .irwrite(irwrite), .iord(iord),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
    .regdest(regdest), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource), .branch(branch),
    .jalcntrl(jalcntrl), .alusrcz(alusrcz), .instret(instret), .badop(badop),
    .state(state)
  );

  always #5 clk = ~clk;

  assign outs = {pcwrite, irwrite, iord, memread, memwrite, memtoreg, regdest,
                 regwrite, alusrca, alusrcb, aluop, pcsource, branch, jalcntrl,
                 alusrcz, instret, badop};

  localparam logic [23:0] PCW = 24'h800000, IRW = 24'h400000, IORD = 24'h200000;
  localparam logic [23:0] MRD = 24'h100000, MWR = 24'h080000, M2R = 24'h040000;
  localparam logic [23:0] RDST = 24'h020000, RW = 24'h010000, SRCA = 24'h008000;
  localparam logic [23:0] SB4 = 24'h002000, SBIMM = 24'h004000, SBSH = 24'h006000;
  localparam logic [23:0] ALUR = 24'h000200, ALUSUB = 24'h000400;
  localparam logic [23:0] ALUAND = 24'h000800, ALUOR = 24'h001000;
  localparam logic [23:0] PCSOUT = 24'h000080, PCSJ = 24'h000100, PCSA = 24'h000180;
  localparam logic [23:0] BEQ = 24'h10, BNE = 24'h20, BGEZ = 24'h30;
  localparam logic [23:0] BGTZ = 24'h40, BLEZ = 24'h50, BLTZ = 24'h60;
  localparam logic [23:0] JALC = 24'h8, ZRO = 24'h4, IRET = 24'h2, BAD = 24'h1;

  localparam logic [23:0] FE   = PCW | IRW | MRD | SB4;
  localparam logic [23:0] DEC  = SBSH;
  localparam logic [23:0] MADR = SRCA | SBIMM;
  localparam logic [23:0] BRX  = SRCA | ALUSUB | PCSOUT | IRET;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [23:0] o;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  task automatic checkOutput(input exp_t x);
    total++;
    if ({state, outs} !== {x.st, x.o}) begin
      bad++;
      $display("[TB] FAIL %s: got state=%0d outs=%h, want state=%0d outs=%h",
               x.name, state, outs, x.st, x.o);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checkOutput(e);
    end
  end

  task automatic setinsn(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] bf);
    opcode  = op;
    func    = fn;
    branchf = bf;
  endtask

  task automatic applyStimulus(input string name, input logic r, input logic mr,
                               input logic [3:0] st, input logic [23:0] o);
    exp_t x;
    rst      = r;
    memready = mr;
    x.name   = name;
    x.st     = st;
    x.o      = o;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    setinsn(6'b101011, 6'd0, 5'd0);
    for (int i = 0; i < 3; i++) applyStimulus("reset", 1'b1, 1'b1, 4'd0, 24'h0);

    setinsn(6'b100011, 6'd0, 5'd0);
    applyStimulus("lw fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("lw decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("lw memadr", 1'b0, 1'b1, 4'd2, MADR);
`ifdef MC_CONTROL_MEMWAIT_EN
    applyStimulus("lw memrd", 1'b0, 1'b1, 4'd3, MRD | IORD);
`else
    applyStimulus("lw memrd ignores memready", 1'b0, 1'b0, 4'd3, MRD | IORD);
`endif
    applyStimulus("lw memwb", 1'b0, 1'b1, 4'd4, RW | M2R | IRET);

    setinsn(6'b101011, 6'd0, 5'd0);
    applyStimulus("sw fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("sw decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("sw memadr", 1'b0, 1'b1, 4'd2, MADR);
    applyStimulus("sw memwr", 1'b0, 1'b1, 4'd5, MWR | IORD | IRET);

    setinsn(6'b000000, 6'b100000, 5'd0);
    applyStimulus("add fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("add decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("add rexec", 1'b0, 1'b1, 4'd6, SRCA | ALUR);
    applyStimulus("add rwb", 1'b0, 1'b1, 4'd7, RW | RDST | IRET);

    setinsn(6'b000000, 6'b001000, 5'd0);
    applyStimulus("jr fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("jr decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("jr exec", 1'b0, 1'b1, 4'd13, PCW | PCSA | IRET);

    setinsn(6'b001000, 6'd0, 5'd0);
    applyStimulus("addi fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("addi decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("addi iexec", 1'b0, 1'b1, 4'd8, SRCA | SBIMM);
    applyStimulus("addi iwb", 1'b0, 1'b1, 4'd9, RW | IRET);

    setinsn(6'b001100, 6'd0, 5'd0);
    applyStimulus("andi fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("andi decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("andi iexec", 1'b0, 1'b1, 4'd8, SRCA | SBIMM | ALUAND);
    applyStimulus("andi iwb", 1'b0, 1'b1, 4'd9, RW | IRET);

    setinsn(6'b001101, 6'd0, 5'd0);
    applyStimulus("ori fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("ori decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("ori iexec", 1'b0, 1'b1, 4'd8, SRCA | SBIMM | ALUOR);
    applyStimulus("ori iwb", 1'b0, 1'b1, 4'd9, RW | IRET);

    setinsn(6'b000001, 6'd0, 5'b00001);
    applyStimulus("bgez fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("bgez decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("bgez branch", 1'b0, 1'b1, 4'd10, BRX | BGEZ | ZRO);

    setinsn(6'b000001, 6'd0, 5'b00000);
    applyStimulus("bltz fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("bltz decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("bltz branch", 1'b0, 1'b1, 4'd10, BRX | BLTZ | ZRO);

    setinsn(6'b000100, 6'd0, 5'd0);
    applyStimulus("beq fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("beq decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("beq branch", 1'b0, 1'b1, 4'd10, BRX | BEQ);

    setinsn(6'b000101, 6'd0, 5'd0);
    applyStimulus("bne fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("bne decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("bne branch", 1'b0, 1'b1, 4'd10, BRX | BNE);

    setinsn(6'b000111, 6'd0, 5'd0);
    applyStimulus("bgtz fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("bgtz decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("bgtz branch", 1'b0, 1'b1, 4'd10, BRX | BGTZ | ZRO);

    setinsn(6'b000110, 6'd0, 5'd0);
    applyStimulus("blez fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("blez decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("blez branch", 1'b0, 1'b1, 4'd10, BRX | BLEZ);

    setinsn(6'b000010, 6'd0, 5'd0);
    applyStimulus("j fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("j decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("j jump", 1'b0, 1'b1, 4'd11, PCW | PCSJ | IRET);

    setinsn(6'b000011, 6'd0, 5'd0);
    applyStimulus("jal fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("jal decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("jal link", 1'b0, 1'b1, 4'd12, PCW | PCSJ | RW | JALC | IRET);

    setinsn(6'b111111, 6'd0, 5'd0);
    applyStimulus("bad fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("bad decode", 1'b0, 1'b1, 4'd1, DEC | BAD);

    setinsn(6'b101011, 6'd0, 5'd0);
    applyStimulus("bad back to fetch", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("abort decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("abort memadr", 1'b0, 1'b1, 4'd2, MADR);
    applyStimulus("abort reset", 1'b1, 1'b1, 4'd0, 24'h0);
    applyStimulus("abort refetch", 1'b0, 1'b1, 4'd0, FE);

`ifdef MC_CONTROL_MEMWAIT_EN
    applyStimulus("wait decode", 1'b0, 1'b1, 4'd1, DEC);
    applyStimulus("wait memadr", 1'b0, 1'b1, 4'd2, MADR);
    applyStimulus("wait memwr 1", 1'b0, 1'b0, 4'd5, MWR | IORD);
    applyStimulus("wait memwr 2", 1'b0, 1'b0, 4'd5, MWR | IORD);
    applyStimulus("wait memwr done", 1'b0, 1'b1, 4'd5, MWR | IORD | IRET);
    applyStimulus("fetch stall", 1'b0, 1'b0, 4'd0, MRD | SB4);
    applyStimulus("fetch done", 1'b0, 1'b1, 4'd0, FE);
    applyStimulus("fetch then decode", 1'b0, 1'b1, 4'd1, DEC);
`endif

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, want finish before 200000");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] timeout");
  end

endmodule
